// File: rtl/demux4_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux4_pkg;

   localparam int DEF_WIDTH   = 4;   // default data word width
   localparam int NCHAN       = 4;   // number of output channels
   localparam int STALL_CNT_W = 8;   // width of the optional stall counter

   typedef logic [1:0] chan_t;       // channel index 0..3

endpackage

// File: rtl/demux4_if.sv
// Bus bundle for demux4_reg: upstream word/select handshake plus the four
// downstream channel registers with their valid/ack handshakes.
//
// Handshake rules:
//   Upstream: a word on d is accepted on a posedge where in_valid & in_ready.
//     in_ready is combinational, never depends on in_valid, and the producer
//     holds d, s and auto stable while stalled.
//   Downstream: channel n holds a word while y_valid[n]=1.  The consumer
//     takes it on a posedge where y_valid[n] & y_ack[n].  y_ack[n] is
//     ignored while y_valid[n]=0.
interface demux4_if #(
   parameter int WIDTH = demux4_pkg::DEF_WIDTH
);
   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             auto;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [3:0]       y_valid;
   logic [3:0]       y_ack;

   // Producer/consumer side (drives data and acks)
   modport master (
      output d, s, auto, in_valid, y_ack,
      input  in_ready, y0, y1, y2, y3, y_valid
   );

   // Demux side
   modport slave (
      input  d, s, auto, in_valid, y_ack,
      output in_ready, y0, y1, y2, y3, y_valid
   );
endinterface

// File: rtl/demux4_chan.sv
// One demux channel: a holding register plus its EMPTY/FULL valid bit.
// A write in the same cycle as an ack wins, so the channel flows through
// without a bubble.
module demux4_chan #(
   parameter int WIDTH = demux4_pkg::DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             ack,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   // Capture on write; clear valid on ack when nothing new arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         dout  <= '0;
         valid <= 1'b0;
      end else if (wr) begin
         dout  <= din;
         valid <= 1'b1;
      end else if (ack) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with explicit (s) or round-robin routing.
// Optional feature macro: DEMUX4_STALL_CNT_EN adds an 8-bit saturating
// count of stall cycles on output drop_cnt.
module demux4_reg
   import demux4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   demux4_if.slave                bus,
`ifdef DEMUX4_STALL_CNT_EN
   output logic [STALL_CNT_W-1:0] drop_cnt,
`endif
   output chan_t                  rr_ptr
);

   chan_t            tgt;
   logic             accept;
   logic [NCHAN-1:0] wr;
   logic [NCHAN-1:0] valid_q;
   logic [WIDTH-1:0] y_q [NCHAN];

   // Target channel, readiness and accept decode
   always_comb begin
      tgt          = bus.auto ? rr_ptr : chan_t'(bus.s);
      bus.in_ready = ~valid_q[tgt] | bus.y_ack[tgt];
      accept       = bus.in_valid & bus.in_ready;
      wr           = '0;
      wr[tgt]      = accept;
   end

   // Round-robin pointer: advances only on an accept in auto mode
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (accept && bus.auto)
         rr_ptr <= rr_ptr + 2'd1;
   end

   for (genvar n = 0; n < NCHAN; n++) begin : g_chan
      demux4_chan #(.WIDTH(WIDTH)) u_chan (
         .clk   (clk),
         .rst   (rst),
         .wr    (wr[n]),
         .din   (bus.d),
         .ack   (bus.y_ack[n]),
         .dout  (y_q[n]),
         .valid (valid_q[n])
      );
   end

   assign bus.y0      = y_q[0];
   assign bus.y1      = y_q[1];
   assign bus.y2      = y_q[2];
   assign bus.y3      = y_q[3];
   assign bus.y_valid = valid_q;

`ifdef DEMUX4_STALL_CNT_EN
   logic stall;
   assign stall = bus.in_valid & ~bus.in_ready;

   // Saturating stall counter, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (stall && (drop_cnt != {STALL_CNT_W{1'b1}}))
         drop_cnt <= drop_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Directed, table-driven bench for demux4_reg with hand-written sequences
// for backpressure and mid-operation reset.
module tb_demux4_reg;
   import demux4_pkg::*;

   localparam int W = 4;

   logic  clk;
   logic  rst;
   chan_t rr_ptr;
`ifdef DEMUX4_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] drop_cnt;
`endif

   demux4_if #(.WIDTH(W)) bus ();

   demux4_reg #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
`ifdef DEMUX4_STALL_CNT_EN
      .drop_cnt (drop_cnt),
`endif
      .rr_ptr   (rr_ptr)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        auto_m;
      logic [1:0]  s;
      logic [3:0]  d;
      logic        iv;
      logic [3:0]  ack;
      logic        chk_rdy;
      logic        exp_rdy;
      logic [15:0] exp_y;     // {y3, y2, y1, y0} after the edge
      logic [3:0]  exp_v;
      logic [1:0]  exp_ptr;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   function automatic vec_t mk(input logic r, input logic a, input logic [1:0] s,
                               input logic [3:0] d, input logic iv, input logic [3:0] ack,
                               input logic cr, input logic er, input logic [15:0] ey,
                               input logic [3:0] ev, input logic [1:0] ep);
      vec_t t;
      t.rst = r; t.auto_m = a; t.s = s; t.d = d; t.iv = iv; t.ack = ack;
      t.chk_rdy = cr; t.exp_rdy = er; t.exp_y = ey; t.exp_v = ev; t.exp_ptr = ep;
      return t;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic a, input logic [1:0] s,
                        input logic [3:0] d, input logic iv, input logic [3:0] ack);
      rst = r; bus.auto = a; bus.s = s; bus.d = d; bus.in_valid = iv; bus.y_ack = ack;
   endtask

   task automatic check_outs(input string tag, input logic [15:0] ey,
                             input logic [3:0] ev, input logic [1:0] ep);
      check({tag, ".y0"},      {12'd0, bus.y0},      {12'd0, ey[3:0]});
      check({tag, ".y1"},      {12'd0, bus.y1},      {12'd0, ey[7:4]});
      check({tag, ".y2"},      {12'd0, bus.y2},      {12'd0, ey[11:8]});
      check({tag, ".y3"},      {12'd0, bus.y3},      {12'd0, ey[15:12]});
      check({tag, ".y_valid"}, {12'd0, bus.y_valid}, {12'd0, ev});
      check({tag, ".rr_ptr"},  {14'd0, rr_ptr},      {14'd0, ep});
   endtask

   // Drive a vector mid-cycle, check in_ready before the edge, outputs after
   task automatic apply(input string tag, input vec_t t);
      @(negedge clk);
      drive(t.rst, t.auto_m, t.s, t.d, t.iv, t.ack);
      #1;
      if (t.chk_rdy)
         check({tag, ".in_ready"}, {15'd0, bus.in_ready}, {15'd0, t.exp_rdy});
      @(posedge clk);
      #1;
      check_outs(tag, t.exp_y, t.exp_v, t.exp_ptr);
   endtask

   vec_t tbl [19];

   initial begin
      drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0);

      //           rst a  s     d     iv ack      cr er  {y3,y2,y1,y0} v        ptr
      tbl[0]  = mk(1, 0, 2'd0, 4'h0, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 2'd0);
      tbl[1]  = mk(1, 0, 2'd0, 4'h0, 0, 4'b0000, 1, 1, 16'h0000, 4'b0000, 2'd0);
      tbl[2]  = mk(0, 0, 2'd0, 4'h0, 0, 4'b0000, 1, 1, 16'h0000, 4'b0000, 2'd0);
      // explicit route to y2, then ack it
      tbl[3]  = mk(0, 0, 2'd2, 4'h5, 1, 4'b0000, 1, 1, 16'h0500, 4'b0100, 2'd0);
      tbl[4]  = mk(0, 0, 2'd0, 4'h0, 0, 4'b0100, 1, 1, 16'h0500, 4'b0000, 2'd0);
      // flow-through on y1: A then C with ack in the same cycle
      tbl[5]  = mk(0, 0, 2'd1, 4'hA, 1, 4'b0000, 1, 1, 16'h05A0, 4'b0010, 2'd0);
      tbl[6]  = mk(0, 0, 2'd1, 4'hC, 1, 4'b0010, 1, 1, 16'h05C0, 4'b0010, 2'd0);
      tbl[7]  = mk(0, 0, 2'd1, 4'h0, 0, 4'b0010, 1, 1, 16'h05C0, 4'b0000, 2'd0);
      // round robin 1..4, 5th stalls, then flows through with ack on y0
      tbl[8]  = mk(0, 1, 2'd0, 4'h1, 1, 4'b0000, 1, 1, 16'h05C1, 4'b0001, 2'd1);
      tbl[9]  = mk(0, 1, 2'd0, 4'h2, 1, 4'b0000, 1, 1, 16'h0521, 4'b0011, 2'd2);
      tbl[10] = mk(0, 1, 2'd0, 4'h3, 1, 4'b0000, 1, 1, 16'h0321, 4'b0111, 2'd3);
      tbl[11] = mk(0, 1, 2'd0, 4'h4, 1, 4'b0000, 1, 1, 16'h4321, 4'b1111, 2'd0);
      tbl[12] = mk(0, 1, 2'd0, 4'h5, 1, 4'b0000, 1, 0, 16'h4321, 4'b1111, 2'd0);
      tbl[13] = mk(0, 1, 2'd0, 4'h5, 1, 4'b0001, 1, 1, 16'h4325, 4'b1111, 2'd1);
      // stall on full y1 while y3 is acked in parallel
      tbl[14] = mk(0, 0, 2'd1, 4'h7, 1, 4'b1000, 1, 0, 16'h4325, 4'b0111, 2'd1);
      // write y3 while y0 is acked
      tbl[15] = mk(0, 0, 2'd3, 4'h9, 1, 4'b0001, 1, 1, 16'h9325, 4'b1110, 2'd1);
      // auto on: target is rr_ptr=1 (full), not s=0 (empty)
      tbl[16] = mk(0, 1, 2'd0, 4'h6, 1, 4'b0000, 1, 0, 16'h9325, 4'b1110, 2'd1);
      // auto off again: s=0 used, rr_ptr holds
      tbl[17] = mk(0, 0, 2'd0, 4'h6, 1, 4'b0000, 1, 1, 16'h9326, 4'b1111, 2'd1);
      // drain all channels, data retained
      tbl[18] = mk(0, 0, 2'd0, 4'h0, 0, 4'b1111, 1, 1, 16'h9326, 4'b0000, 2'd1);

      for (int i = 0; i < 19; i++)
         apply($sformatf("vec%0d", i), tbl[i]);

      // Backpressure on y3 with a fresh stall counter
      apply("bp_rst",  mk(1, 0, 2'd0, 4'h0, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 2'd0));
      apply("bp_fill", mk(0, 0, 2'd3, 4'hA, 1, 4'b0000, 1, 1, 16'hA000, 4'b1000, 2'd0));
      for (int i = 0; i < 3; i++)
         apply($sformatf("bp_stall%0d", i),
               mk(0, 0, 2'd3, 4'hB, 1, 4'b0000, 1, 0, 16'hA000, 4'b1000, 2'd0));
`ifdef DEMUX4_STALL_CNT_EN
      check("drop_cnt_after_stall", {8'd0, drop_cnt}, 16'd3);
`endif
      apply("bp_ack",  mk(0, 0, 2'd3, 4'hB, 1, 4'b1000, 1, 1, 16'hB000, 4'b1000, 2'd0));
`ifdef DEMUX4_STALL_CNT_EN
      check("drop_cnt_hold", {8'd0, drop_cnt}, 16'd3);
`endif

      // Reset mid-operation: fill all with rr_ptr=2, then pulse reset
      apply("mr_a", mk(0, 1, 2'd0, 4'h1, 1, 4'b0000, 1, 1, 16'hB001, 4'b1001, 2'd1));
      apply("mr_b", mk(0, 1, 2'd0, 4'h2, 1, 4'b0000, 1, 1, 16'hB021, 4'b1011, 2'd2));
      apply("mr_c", mk(0, 0, 2'd2, 4'h3, 1, 4'b0000, 1, 1, 16'hB321, 4'b1111, 2'd2));
      apply("mr_rst", mk(1, 1, 2'd0, 4'h0, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 2'd0));
`ifdef DEMUX4_STALL_CNT_EN
      check("drop_cnt_reset", {8'd0, drop_cnt}, 16'd0);
`endif
      apply("mr_next", mk(0, 1, 2'd3, 4'hE, 1, 4'b0000, 1, 1, 16'h000E, 4'b0001, 2'd1));

      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
